// File: rtl/pp_pkg.sv
// Shared types and default sizing for the patch paste stage.
//   pixel_t       : one pixel at the default pixel width
//   paste_state_t : control FSM states (IDLE, RUN, DONE)
//   PP_*          : default parameter values used by the interface and modules
package pp_pkg;

  localparam int PP_PIXEL_BIT_WIDTH = 10;
  localparam int PP_FRAME_ROWS      = 20;
  localparam int PP_FRAME_COLS      = 20;
  localparam int PP_PATCH_ROWS      = 10;
  localparam int PP_PATCH_COLS      = 10;

  typedef logic [PP_PIXEL_BIT_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } paste_state_t;

endpackage

// File: rtl/patch_paste_if.sv
// Bus bundle for patch_paste: control handshake, patch input stream,
// frame output stream and the raster counters exported to the crop side.
//   slave  : view of the patch_paste block itself
//   master : view of the environment driving/consuming the block
interface patch_paste_if
  import pp_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = PP_PIXEL_BIT_WIDTH,
  parameter int FRAME_ROWS      = PP_FRAME_ROWS,
  parameter int FRAME_COLS      = PP_FRAME_COLS
);

  localparam int CW = $clog2(FRAME_COLS);
  localparam int RW = $clog2(FRAME_ROWS);

  logic                       ap_start;
  logic                       ap_done;
  logic                       ap_idle;
  logic [CW-1:0]              paste_x0;
  logic [RW-1:0]              paste_y0;
  logic                       s_axis_tvalid;
  logic                       s_axis_tready;
  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata;
  logic                       m_axis_tvalid;
  logic                       m_axis_tready;
  logic [PIXEL_BIT_WIDTH-1:0] m_axis_tdata;
  logic                       m_axis_tuser;
  logic                       m_axis_tlast;
  logic [CW-1:0]              cnt_col;
  logic [RW-1:0]              cnt_row;

  modport slave (
    input  ap_start, paste_x0, paste_y0,
    input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output ap_done, ap_idle, s_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast,
    output cnt_col, cnt_row
  );

  modport master (
    output ap_start, paste_x0, paste_y0,
    output s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input  ap_done, ap_idle, s_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast,
    input  cnt_col, cnt_row
  );

endinterface

// File: rtl/raster_counter.sv
// Column/row raster position counter with enable and wrap.
//   clk, rst_n : clock, async active-low reset
//   i_clr      : synchronous clear to (0,0)
//   i_en       : advance one position
//   o_col/o_row: current position
//   o_eof      : current position is the last pixel of the frame
module raster_counter #(
  parameter int COLS = 20,
  parameter int ROWS = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic                    i_en,
  output logic [$clog2(COLS)-1:0] o_col,
  output logic [$clog2(ROWS)-1:0] o_row,
  output logic                    o_eof
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_col_end;
  logic          w_row_end;

  assign w_col_end = (r_col == CW'(COLS - 1));
  assign w_row_end = (r_row == RW'(ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      if (w_col_end) begin
        r_col <= '0;
        // Wrapping out of the last row returns to (0,0) ready for the next frame
        r_row <= w_row_end ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign o_col = r_col;
  assign o_row = r_row;
  assign o_eof = w_col_end && w_row_end;

endmodule

// File: rtl/patch_paste.sv
// Re-inserts a PATCH_ROWS x PATCH_COLS pixel stream into a FRAME_ROWS x
// FRAME_COLS raster at a latched (x0,y0); pixels outside the window are BG_VALUE.
//   clk           : clock
//   s_axis_resetn : async active-low reset
//   bus (slave)   : ap_start/ap_done/ap_idle, paste_x0/y0, s_axis patch in,
//                   m_axis frame out (tuser = SOF, tlast = EOL), cnt_col/cnt_row
module patch_paste
  import pp_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = PP_PIXEL_BIT_WIDTH,
  parameter int FRAME_ROWS      = PP_FRAME_ROWS,
  parameter int FRAME_COLS      = PP_FRAME_COLS,
  parameter int PATCH_ROWS      = PP_PATCH_ROWS,
  parameter int PATCH_COLS      = PP_PATCH_COLS,
  parameter logic [PIXEL_BIT_WIDTH-1:0] BG_VALUE = '0
) (
  input logic          clk,
  input logic          s_axis_resetn,
  patch_paste_if.slave bus
);

  localparam int CW = $clog2(FRAME_COLS);
  localparam int RW = $clog2(FRAME_ROWS);
  localparam logic [CW-1:0] X_MAX = CW'(FRAME_COLS - PATCH_COLS);
  localparam logic [RW-1:0] Y_MAX = RW'(FRAME_ROWS - PATCH_ROWS);

  function automatic logic [CW-1:0] clamp_x(input logic [CW-1:0] x);
    return (x > X_MAX) ? X_MAX : x;
  endfunction

  function automatic logic [RW-1:0] clamp_y(input logic [RW-1:0] y);
    return (y > Y_MAX) ? Y_MAX : y;
  endfunction

  paste_state_t r_state, w_next;

  logic [CW-1:0]              r_x0;
  logic [RW-1:0]              r_y0;
  logic                       r_gen_done;
  logic                       r_m_tvalid;
  logic [PIXEL_BIT_WIDTH-1:0] r_m_tdata;
  logic                       r_m_tuser;
  logic                       r_m_tlast;
  logic                       r_m_eof;

  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_eof;
  logic          w_run;
  logic          w_adv;
  logic          w_load;
  logic          w_in_win;
  logic          w_last_acc;
  logic [CW:0]   w_x_hi;
  logic [RW:0]   w_y_hi;

  raster_counter #(
    .COLS(FRAME_COLS),
    .ROWS(FRAME_ROWS)
  ) u_cnt (
    .clk  (clk),
    .rst_n(s_axis_resetn),
    .i_clr(r_state == IDLE),
    .i_en (w_load),
    .o_col(w_col),
    .o_row(w_row),
    .o_eof(w_eof)
  );

  // Window bounds one bit wider than the counters so x0+PATCH_COLS cannot wrap
  assign w_x_hi   = {1'b0, r_x0} + (CW+1)'(PATCH_COLS);
  assign w_y_hi   = {1'b0, r_y0} + (RW+1)'(PATCH_ROWS);
  assign w_in_win = ({1'b0, w_row} >= {1'b0, r_y0}) && ({1'b0, w_row} < w_y_hi) &&
                    ({1'b0, w_col} >= {1'b0, r_x0}) && ({1'b0, w_col} < w_x_hi);

  // Once the final pixel is generated the counters have wrapped to (0,0);
  // r_gen_done stops a second frame from starting while it drains.
  assign w_run      = (r_state == RUN);
  assign w_adv      = w_run && !r_gen_done && (!r_m_tvalid || bus.m_axis_tready);
  assign w_load     = w_adv && (!w_in_win || bus.s_axis_tvalid);
  assign w_last_acc = r_m_tvalid && bus.m_axis_tready && r_m_eof;

  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) r_state <= IDLE;
    else                r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    bus.ap_idle = 1'b0;
    bus.ap_done = 1'b0;
    case (r_state)
      IDLE: begin
        bus.ap_idle = 1'b1;
        if (bus.ap_start) w_next = RUN;
      end
      RUN: begin
        if (w_last_acc) w_next = DONE;
      end
      DONE: begin
        bus.ap_done = 1'b1;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Coordinates latch only in IDLE, so a mid-frame ap_start cannot move the window
  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      r_x0       <= '0;
      r_y0       <= '0;
      r_gen_done <= 1'b0;
    end else if (r_state == IDLE && bus.ap_start) begin
      r_x0       <= clamp_x(bus.paste_x0);
      r_y0       <= clamp_y(bus.paste_y0);
      r_gen_done <= 1'b0;
    end else if (w_load && w_eof) begin
      r_gen_done <= 1'b1;
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tuser  <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_eof    <= 1'b0;
    end else if (w_load) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= w_in_win ? bus.s_axis_tdata : BG_VALUE;
      r_m_tuser  <= (w_col == '0) && (w_row == '0);
      r_m_tlast  <= (w_col == CW'(FRAME_COLS - 1));
      r_m_eof    <= w_eof;
    end else if (bus.m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign bus.s_axis_tready = w_adv && w_in_win;
  assign bus.m_axis_tvalid = r_m_tvalid;
  assign bus.m_axis_tdata  = r_m_tdata;
  assign bus.m_axis_tuser  = r_m_tuser;
  assign bus.m_axis_tlast  = r_m_tlast;
  assign bus.cnt_col       = w_col;
  assign bus.cnt_row       = w_row;

endmodule

// File: tb/tb_patch_paste.sv
module tb_patch_paste;
  import pp_pkg::*;

  localparam int PW = 10;
  localparam int FR = 20;
  localparam int FC = 20;
  localparam int CW = $clog2(FC);
  localparam int RW = $clog2(FR);
  localparam int NPIX = FR * FC;

  logic clk = 1'b0;
  logic s_axis_resetn;
  always #5 clk = ~clk;

  patch_paste_if #(.PIXEL_BIT_WIDTH(PW), .FRAME_ROWS(FR), .FRAME_COLS(FC)) if_a ();
  patch_paste_if #(.PIXEL_BIT_WIDTH(PW), .FRAME_ROWS(FR), .FRAME_COLS(FC)) if_b ();

  patch_paste #(.PIXEL_BIT_WIDTH(PW), .FRAME_ROWS(FR), .FRAME_COLS(FC),
                .PATCH_ROWS(10), .PATCH_COLS(10), .BG_VALUE('0)) dut_a (
    .clk(clk), .s_axis_resetn(s_axis_resetn), .bus(if_a.slave));

  patch_paste #(.PIXEL_BIT_WIDTH(PW), .FRAME_ROWS(FR), .FRAME_COLS(FC),
                .PATCH_ROWS(20), .PATCH_COLS(20), .BG_VALUE('0)) dut_b (
    .clk(clk), .s_axis_resetn(s_axis_resetn), .bus(if_b.slave));

  int checks = 0;
  int failures = 0;

  // Results of the most recent run_a
  pixel_t got_d [NPIX];
  logic   got_u [NPIX];
  logic   got_l [NPIX];
  int n_out, s_cnt, done_cnt, done_cyc, last_acc_cyc, stall_err;

  // Drive one frame through dut_a and capture every accepted output pixel
  task automatic run_a(input int x0, input int y0, input bit rnd, input int base,
                       input int restart_at, input int rx0, input int ry0,
                       input int abort_at);
    pixel_t held;
    bit holding;
    int cyc, post;
    n_out = 0; s_cnt = 0; done_cnt = 0; done_cyc = -1; last_acc_cyc = -1;
    stall_err = 0; holding = 1'b0; held = '0; post = -1;
    @(posedge clk); #1;
    if_a.paste_x0 = CW'(x0);
    if_a.paste_y0 = RW'(y0);
    if_a.ap_start = 1'b1;
    @(posedge clk); #1;
    if_a.ap_start = 1'b0;
    cyc = 0;
    while (cyc < 4000) begin
      if_a.m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if_a.s_axis_tvalid = (s_cnt < 100) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      if_a.s_axis_tdata  = PW'(base + s_cnt);
      if (cyc == restart_at) begin
        if_a.paste_x0 = CW'(rx0);
        if_a.paste_y0 = RW'(ry0);
        if_a.ap_start = 1'b1;
      end else begin
        if_a.ap_start = 1'b0;
      end
      #1;
      if (holding && if_a.m_axis_tvalid && (if_a.m_axis_tdata !== held)) stall_err++;
      holding = if_a.m_axis_tvalid && !if_a.m_axis_tready;
      held    = if_a.m_axis_tdata;
      if (if_a.m_axis_tvalid && if_a.m_axis_tready) begin
        if (n_out < NPIX) begin
          got_d[n_out] = if_a.m_axis_tdata;
          got_u[n_out] = if_a.m_axis_tuser;
          got_l[n_out] = if_a.m_axis_tlast;
        end
        n_out++;
        last_acc_cyc = cyc;
      end
      if (if_a.s_axis_tvalid && if_a.s_axis_tready) s_cnt++;
      if (if_a.ap_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (abort_at >= 0 && n_out == abort_at) break;
      if (done_cnt > 0 && post < 0) post = cyc + 3;
      if (cyc == post) break;
      @(posedge clk); #1;
      cyc++;
    end
    if_a.s_axis_tvalid = 1'b0;
    if_a.ap_start      = 1'b0;
  endtask

  // Count captured pixels whose data differs from the window model
  function automatic int data_errs(input int x0c, input int y0c, input int base);
    int e = 0;
    for (int i = 0; i < NPIX; i++) begin
      int r = i / FC;
      int c = i % FC;
      int ev = 0;
      if (r >= y0c && r < y0c + 10 && c >= x0c && c < x0c + 10)
        ev = base + (r - y0c) * 10 + (c - x0c);
      if (got_d[i] !== PW'(ev)) e++;
    end
    return e;
  endfunction

  function automatic int flag_errs();
    int e = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (got_u[i] !== (i == 0)) e++;
      if (got_l[i] !== ((i % FC) == FC - 1)) e++;
    end
    return e;
  endfunction

  task automatic test_reset();
    s_axis_resetn = 1'b0;
    #23;
    checks++;
    if (if_a.ap_idle !== 1'b1 || if_a.ap_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: idle=%b done=%b required idle=1 done=0", if_a.ap_idle, if_a.ap_done);
    end
    checks++;
    if (if_a.m_axis_tvalid !== 1'b0 || if_a.s_axis_tready !== 1'b0 ||
        if_a.m_axis_tuser !== 1'b0 || if_a.m_axis_tlast !== 1'b0 || if_a.m_axis_tdata !== '0) begin
      failures++;
      $display("FAIL reset_stream: mv=%b sr=%b u=%b l=%b d=%0d required all 0",
               if_a.m_axis_tvalid, if_a.s_axis_tready, if_a.m_axis_tuser,
               if_a.m_axis_tlast, if_a.m_axis_tdata);
    end
    checks++;
    if (if_a.cnt_col !== '0 || if_a.cnt_row !== '0) begin
      failures++;
      $display("FAIL reset_cnt: col=%0d row=%0d required 0 0", if_a.cnt_col, if_a.cnt_row);
    end
    @(negedge clk);
    s_axis_resetn = 1'b1;
  endtask

  task automatic test_basic();
    int de, fe;
    run_a(5, 5, 1'b0, 0, -1, 0, 0, -1);
    de = data_errs(5, 5, 0);
    fe = flag_errs();
    checks++;
    if (n_out !== NPIX) begin failures++; $display("FAIL basic_count: got %0d required %0d", n_out, NPIX); end
    checks++;
    if (de !== 0) begin failures++; $display("FAIL basic_data: %0d bad pixels required 0", de); end
    checks++;
    if (fe !== 0) begin failures++; $display("FAIL basic_flags: %0d bad tuser/tlast required 0", fe); end
    checks++;
    if (got_d[5*FC+14] !== PW'(9) || got_d[14*FC+14] !== PW'(99) || got_d[5*FC+4] !== PW'(0)) begin
      failures++;
      $display("FAIL basic_spot: r5c14=%0d r14c14=%0d r5c4=%0d required 9 99 0",
               got_d[5*FC+14], got_d[14*FC+14], got_d[5*FC+4]);
    end
    checks++;
    if (s_cnt !== 100) begin failures++; $display("FAIL basic_consumed: got %0d required 100", s_cnt); end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 401) begin
      failures++;
      $display("FAIL basic_done: pulses=%0d cycle=%0d required 1 at 401", done_cnt, done_cyc);
    end
    checks++;
    if (if_a.ap_idle !== 1'b1 || if_a.cnt_col !== '0 || if_a.cnt_row !== '0) begin
      failures++;
      $display("FAIL basic_idle: idle=%b col=%0d row=%0d required 1 0 0",
               if_a.ap_idle, if_a.cnt_col, if_a.cnt_row);
    end
  endtask

  task automatic test_clamp();
    int de;
    run_a(15, 18, 1'b0, 500, -1, 0, 0, -1);
    de = data_errs(10, 10, 500);
    checks++;
    if (de !== 0 || n_out !== NPIX) begin
      failures++;
      $display("FAIL clamp_data: bad=%0d count=%0d required 0 and %0d", de, n_out, NPIX);
    end
    checks++;
    if (got_d[NPIX-1] !== PW'(599) || got_d[10*FC+10] !== PW'(500) || got_d[9*FC+19] !== PW'(0)) begin
      failures++;
      $display("FAIL clamp_spot: last=%0d r10c10=%0d r9c19=%0d required 599 500 0",
               got_d[NPIX-1], got_d[10*FC+10], got_d[9*FC+19]);
    end
  endtask

  task automatic test_random_stall();
    int de, fe;
    run_a(5, 5, 1'b1, 0, -1, 0, 0, -1);
    de = data_errs(5, 5, 0);
    fe = flag_errs();
    checks++;
    if (n_out !== NPIX || de !== 0 || fe !== 0) begin
      failures++;
      $display("FAIL stall_seq: count=%0d bad_data=%0d bad_flags=%0d required %0d 0 0", n_out, de, fe, NPIX);
    end
    checks++;
    if (stall_err !== 0) begin failures++; $display("FAIL stall_hold: %0d changes while stalled required 0", stall_err); end
    checks++;
    if (done_cnt !== 1 || done_cyc !== last_acc_cyc + 1) begin
      failures++;
      $display("FAIL stall_done: pulses=%0d cycle=%0d required 1 at %0d", done_cnt, done_cyc, last_acc_cyc + 1);
    end
  endtask

  task automatic test_full_window();
    int n, sc, cyc, de, re;
    bit exp_rdy, sof;
    n = 0; sc = 0; cyc = 0; de = 0; re = 0; sof = 1'b0;
    @(posedge clk); #1;
    if_b.paste_x0 = CW'(7);
    if_b.paste_y0 = RW'(3);
    if_b.ap_start = 1'b1;
    @(posedge clk); #1;
    if_b.ap_start = 1'b0;
    while (cyc < 4000 && n < NPIX) begin
      if_b.m_axis_tready = 1'($urandom_range(0, 1));
      if_b.s_axis_tvalid = (sc < NPIX) && ($urandom_range(0, 3) != 0);
      if_b.s_axis_tdata  = PW'(sc);
      #1;
      exp_rdy = (sc < NPIX) && (!if_b.m_axis_tvalid || if_b.m_axis_tready);
      if (if_b.s_axis_tready !== exp_rdy) re++;
      if (if_b.m_axis_tvalid && if_b.m_axis_tready) begin
        if (if_b.m_axis_tdata !== PW'(n)) de++;
        if (n == 0) sof = if_b.m_axis_tuser;
        n++;
      end
      if (if_b.s_axis_tvalid && if_b.s_axis_tready) sc++;
      @(posedge clk); #1;
      cyc++;
    end
    if_b.s_axis_tvalid = 1'b0;
    checks++;
    if (n !== NPIX || de !== 0) begin
      failures++;
      $display("FAIL full_passthru: count=%0d bad=%0d required %0d 0", n, de, NPIX);
    end
    checks++;
    if (re !== 0) begin failures++; $display("FAIL full_tready: %0d cycles off adv required 0", re); end
    checks++;
    if (sof !== 1'b1 || if_b.ap_done !== 1'b1) begin
      failures++;
      $display("FAIL full_sof_done: tuser0=%b done=%b required 1 1", sof, if_b.ap_done);
    end
    if_b.m_axis_tready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int de;
    run_a(5, 5, 1'b0, 0, -1, 0, 0, 150);
    s_axis_resetn = 1'b0;
    #1;
    checks++;
    if (if_a.ap_idle !== 1'b1 || if_a.m_axis_tvalid !== 1'b0 || if_a.ap_done !== 1'b0 ||
        if_a.cnt_col !== '0 || if_a.cnt_row !== '0) begin
      failures++;
      $display("FAIL abort_now: idle=%b mv=%b done=%b col=%0d row=%0d required 1 0 0 0 0",
               if_a.ap_idle, if_a.m_axis_tvalid, if_a.ap_done, if_a.cnt_col, if_a.cnt_row);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    s_axis_resetn = 1'b1;
    run_a(0, 0, 1'b0, 0, -1, 0, 0, -1);
    de = data_errs(0, 0, 0);
    checks++;
    if (n_out !== NPIX || de !== 0 || got_u[0] !== 1'b1 || done_cnt !== 1) begin
      failures++;
      $display("FAIL abort_restart: count=%0d bad=%0d tuser0=%b done=%0d required %0d 0 1 1",
               n_out, de, got_u[0], done_cnt, NPIX);
    end
  endtask

  task automatic test_restart_ignored();
    int de;
    run_a(3, 7, 1'b0, 0, 50, 12, 2, -1);
    de = data_errs(3, 7, 0);
    checks++;
    if (n_out !== NPIX || de !== 0 || done_cnt !== 1) begin
      failures++;
      $display("FAIL restart_ignored: count=%0d bad=%0d done=%0d required %0d 0 1", n_out, de, done_cnt, NPIX);
    end
  endtask

  initial begin
    if_a.ap_start = 1'b0; if_a.paste_x0 = '0; if_a.paste_y0 = '0;
    if_a.s_axis_tvalid = 1'b0; if_a.s_axis_tdata = '0; if_a.m_axis_tready = 1'b1;
    if_b.ap_start = 1'b0; if_b.paste_x0 = '0; if_b.paste_y0 = '0;
    if_b.s_axis_tvalid = 1'b0; if_b.s_axis_tdata = '0; if_b.m_axis_tready = 1'b1;
    test_reset();
    test_basic();
    test_clamp();
    test_random_stall();
    test_full_window();
    test_abort();
    test_restart_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
